vector_operand_packer: RTL and testbench
========================================

# vector_operand_packer

Downstream consumer of the 20-bit hex-vector word memory. On `start` it walks `NUM_WORDS` consecutive addresses of that memory, absorbs its one-cycle registered read latency, and packs the returned words into a single wide operand. The operand is presented to the RSA datapath over a valid/ready handshake. The block bridges file-loaded test vectors to the 80-bit-and-wider operand inputs used by the modular-arithmetic stages.

## Interface
- `WORD_W`, default 20: width of one memory word (five hex digits).
- `NUM_WORDS`, default 4: words packed per operand; must be ≥ 2.
- `ADDR_W`, default 2: memory address width; 2^ADDR_W ≥ NUM_WORDS.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request one operand fetch; sampled only in IDLE.
- `base_addr` input ADDR_W: first word address; captured on the edge that accepts `start`.
- `mem_addr` output ADDR_W: registered read address to the word memory.
- `mem_rdata` input WORD_W: memory read data, valid one cycle after `mem_addr` is presented.
- `op_data` output WORD_W*NUM_WORDS: packed operand; word k occupies bits [k*WORD_W +: WORD_W], so word 0 is in the LSBs.
- `op_valid` output 1: operand available.
- `op_ready` input 1: consumer accepts when `op_valid && op_ready` at a rising edge.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in the cycle after the handshake completes.

## Operation
- States:
  - IDLE → FETCH when `start` = 1. On that edge: latch `base_addr`, set `mem_addr` = base, clear the issue and capture counters.
  - FETCH: each edge advances `mem_addr` by 1 until NUM_WORDS addresses have been issued. A one-bit read-pending pipeline register tracks the data return. Each edge with read-pending set writes `mem_rdata` into word slot `cap_cnt` and increments `cap_cnt`. Address issue and capture overlap.
  - FETCH → PRESENT on the edge that captures word NUM_WORDS-1; `op_valid` rises on that edge.
  - PRESENT: hold `op_valid` and `op_data` stable until `op_ready` = 1. On the accepting edge: PRESENT → IDLE, `op_valid` falls, `done` = 1 for one cycle.
- Address arithmetic is modulo 2^ADDR_W. An address past the top wraps to 0, and the word order in `op_data` follows issue order, not absolute address.
- `mem_addr` holds its last issued value after FETCH; it does not return to 0.
- Slots not yet captured keep the previous operand's contents. The consumer may only interpret `op_data` while `op_valid` is high.
- `start` while busy is ignored and not queued. `base_addr` changes after acceptance have no effect.
- `op_ready` outside PRESENT is ignored.

## Timing
- Reset values: `mem_addr` = 0, `op_data` = 0, `op_valid` = 0, `busy` = 0, `done` = 0, state IDLE, counters 0.
- Reset asserted at any time, including mid-FETCH or PRESENT, clears everything immediately and asynchronously. The in-flight operand is discarded, with no `done` and no partial `op_valid`. After release, the block waits for a fresh `start`.
- Start latency, with edge E0 accepting `start`:
  - address base+k is driven after edge E_k;
  - word k is captured at edge E_{k+2};
  - `op_valid` goes high after E_{NUM_WORDS+1`}, which is 5 cycles for NUM_WORDS = 4.
- `busy` is high from after E0 through the accepting edge and low after it. `done` is high in the cycle after the accepting edge.
- Throughput: with `start` held high and `op_ready` = 1, the next `start` is accepted at the edge following the accept. That gives one operand every NUM_WORDS+3 cycles.

## Test plan
Memory preload for all scenarios: mem[0] = 20'h12345, mem[1] = 20'hABCDE, mem[2] = 20'h00001, mem[3] = 20'hFFFFF.
- **Basic fetch:** `base_addr` = 0, `start` pulse, `op_ready` = 1 → `mem_addr` sequence 0,1,2,3; `op_valid` 5 cycles after the start edge; `op_data` = 80'hFFFFF_00001_ABCDE_12345; `done` pulse one cycle later.
- **Wrap-around:** `base_addr` = 3 → addresses 3,0,1,2; `op_data` = 80'h00001_ABCDE_12345_FFFFF.
- **Backpressure:** `op_ready` = 0 for 10 cycles after `op_valid` rises, with `start` and `base_addr` toggling → `op_valid` and `op_data` stable, `busy` = 1, no new fetch. Raise `op_ready` → single accept, then `done`, then IDLE.
- **Reset mid-FETCH:** assert `reset` two cycles after `start` → all outputs at reset values immediately, no `done`. After release with `start` low, the block stays IDLE with `mem_addr` = 0.
- **Back-to-back:** `start` held high, `op_ready` = 1, `base_addr` = 0 → two identical operands, `op_valid` rising edges 7 cycles apart, exactly one `done` per operand.
- **Early op_ready:** `op_ready` held high from before `start` → no spurious accept in FETCH; accept occurs on the first edge with `op_valid` high.

Source files
------------

// File: rtl/vector_operand_packer.sv
// vector_operand_packer: reads NUM_WORDS consecutive words from a memory with
// one cycle of registered read latency, packs them into one wide operand, and
// hands the operand off over a valid/ready handshake.
module vector_operand_packer #(
    parameter int unsigned WORD_W    = 20,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic [WORD_W*NUM_WORDS-1:0] op_data,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned IW = $clog2(NUM_WORDS + 1);
    localparam int unsigned CW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] ISSUE_ALL = IW'(NUM_WORDS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   iss_cnt;
    logic [CW-1:0]   cap_cnt;
    logic            addr_live;
    logic            rd_pending;
    logic            accept_start;
    logic            last_capture;
    logic            handshake;

    // Qualified events shared by the FSM and the datapath
    always_comb begin
        accept_start = (state == IDLE) && start;
        last_capture = (state == FETCH) && rd_pending && (cap_cnt == LAST_SLOT);
        handshake    = (state == PRESENT) && op_ready;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept_start) state_next = FETCH;
            FETCH:   if (last_capture) state_next = PRESENT;
            PRESENT: if (handshake)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Address issue and read-pending tracking; addr_live marks a freshly
    // issued address whose data returns one edge later (rd_pending)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr   <= '0;
            iss_cnt    <= '0;
            cap_cnt    <= '0;
            addr_live  <= 1'b0;
            rd_pending <= 1'b0;
        end else if (accept_start) begin
            mem_addr   <= base_addr;
            iss_cnt    <= IW'(1);
            cap_cnt    <= '0;
            addr_live  <= 1'b1;
            rd_pending <= 1'b0;
        end else if (state == FETCH) begin
            rd_pending <= addr_live;
            if (iss_cnt != ISSUE_ALL) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                iss_cnt   <= iss_cnt + IW'(1);
                addr_live <= 1'b1;
            end else begin
                addr_live <= 1'b0;
            end
            if (rd_pending) cap_cnt <= cap_cnt + CW'(1);
        end
    end

    // Operand capture: returned word lands in the slot of its issue order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_data <= '0;
        end else if ((state == FETCH) && rd_pending) begin
            op_data[WORD_W*32'(cap_cnt) +: WORD_W] <= mem_rdata;
        end
    end

    // Completion pulse in the cycle after the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done <= 1'b0;
        else       done <= handshake;
    end

    assign op_valid = (state == PRESENT);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_vector_operand_packer.sv
// Testbench for vector_operand_packer: word memory model plus a reference
// model that builds the expected operand directly from memory contents.
module tb_vector_operand_packer;

    localparam int unsigned WORD_W    = 20;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned OP_W      = WORD_W * NUM_WORDS;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [OP_W-1:0]   op_data;
    logic              op_valid;
    logic              op_ready;
    logic              busy;
    logic              done;

    logic [WORD_W-1:0] mem [4];

    int asserts  = 0;
    int failures = 0;

    vector_operand_packer #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .op_data  (op_data),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read word memory
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [OP_W-1:0] model_operand(input int base);
        logic [OP_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NUM_WORDS); k++)
            r[k*WORD_W +: WORD_W] = mem[(base + k) % 4];
        return r;
    endfunction

    task automatic preload();
        mem[0] = 20'h12345;
        mem[1] = 20'hABCDE;
        mem[2] = 20'h00001;
        mem[3] = 20'hFFFFF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        asserts++;
        if ({mem_addr, op_data, op_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0h data=%0h valid=%0b busy=%0b done=%0b, want all zero",
                     mem_addr, op_data, op_valid, busy, done);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One full fetch with op_ready held high from before start
    task automatic test_fetch(input int base, input string name);
        logic [OP_W-1:0] exp;
        int cyc;
        exp = model_operand(base);
        base_addr = ADDR_W'(base);
        start = 1'b1;
        op_ready = 1'b1;
        tick();                       // E0
        start = 1'b0;
        base_addr = ADDR_W'(base + 1);
        cyc = 0;
        while (!op_valid && cyc < 20) begin
            if (cyc < int'(NUM_WORDS)) begin
                asserts++;
                if (mem_addr !== ADDR_W'((base + cyc) % 4)) begin
                    failures++;
                    $display("FAIL %s_addr%0d: got %0h want %0h", name, cyc, mem_addr, (base + cyc) % 4);
                end
            end
            asserts++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_c%0d: got busy=%0b done=%0b want busy=1 done=0", name, cyc, busy, done);
            end
            tick();
            cyc++;
        end
        asserts++;
        if (cyc != int'(NUM_WORDS) + 1) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, NUM_WORDS + 1);
        end
        asserts++;
        if (op_data !== exp) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", name, op_data, exp);
        end
        asserts++;
        if (mem_addr !== ADDR_W'((base + 3) % 4)) begin
            failures++;
            $display("FAIL %s_addr_hold: got %0h want %0h", name, mem_addr, (base + 3) % 4);
        end
        tick();                       // accepting edge
        asserts++;
        if (done !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: got done=%0b valid=%0b busy=%0b want 1 0 0", name, done, op_valid, busy);
        end
        tick();
        asserts++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: got done=%0b busy=%0b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [OP_W-1:0] exp;
        int cyc;
        exp = model_operand(1);
        op_ready = 1'b0;
        base_addr = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!op_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        asserts++;
        if (op_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid_timeout: got valid=%0b want 1", op_valid);
        end
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom_range(0, 1));
            base_addr = ADDR_W'($urandom);
            tick();
            asserts++;
            if (op_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || op_data !== exp || mem_addr !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%0b busy=%0b done=%0b addr=%0h data=%h want 1 1 0 0 %h",
                         i, op_valid, busy, done, mem_addr, op_data, exp);
            end
        end
        start = 1'b0;
        op_ready = 1'b1;
        tick();
        asserts++;
        if (done !== 1'b1 || op_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: got done=%0b valid=%0b want 1 0", done, op_valid);
        end
        tick();
        asserts++;
        if (done !== 1'b0 || busy !== 1'b0 || op_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: got done=%0b busy=%0b valid=%0b want 0 0 0", done, busy, op_valid);
        end
    endtask

    task automatic test_reset_mid_fetch();
        op_ready = 1'b1;
        base_addr = 2'd2;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        asserts++;
        if ({mem_addr, op_data, op_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: got addr=%0h data=%0h valid=%0b busy=%0b done=%0b want all zero",
                     mem_addr, op_data, op_valid, busy, done);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            asserts++;
            if (busy !== 1'b0 || done !== 1'b0 || op_valid !== 1'b0 || mem_addr !== 2'd0) begin
                failures++;
                $display("FAIL rst_mid_idle%0d: got busy=%0b done=%0b valid=%0b addr=%0h want 0 0 0 0",
                         i, busy, done, op_valid, mem_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] exp;
        logic prev;
        int rises, dones, first, second, cyc;
        exp = model_operand(0);
        base_addr = 2'd0;
        op_ready = 1'b1;
        start = 1'b1;
        prev = op_valid;
        rises = 0;
        dones = 0;
        first = -1;
        second = -1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (op_valid && !prev) begin
                rises++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                asserts++;
                if (op_data !== exp) begin
                    failures++;
                    $display("FAIL b2b_data_c%0d: got %h want %h", c, op_data, exp);
                end
            end
            if (done) dones++;
            prev = op_valid;
        end
        start = 1'b0;
        asserts++;
        if (rises != 2 || dones != 2) begin
            failures++;
            $display("FAIL b2b_counts: got rises=%0d dones=%0d want 2 2", rises, dones);
        end
        asserts++;
        if (second - first != int'(NUM_WORDS) + 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want %0d", second - first, NUM_WORDS + 3);
        end
        cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_random_fetches();
        for (int i = 0; i < 6; i++) begin
            for (int a = 0; a < 4; a++) mem[a] = WORD_W'($urandom);
            test_fetch(int'($urandom_range(0, 3)), "rand");
        end
        preload();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        op_ready = 1'b0;
        preload();
        #2;
        test_reset();
        test_fetch(0, "basic");
        test_fetch(3, "wrap");
        test_backpressure();
        test_reset_mid_fetch();
        test_back_to_back();
        test_random_fetches();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
